// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction-fetch front end feeding decode through a DEPTH-entry in-order buffer.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect targets become a fault entry).
module fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     DEPTH        = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_fault,
    input  logic            instr_ready
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

    typedef logic [PW-1:0] ptr_t;

    logic [XLEN-1:0] fetch_pc;
    ptr_t            alloc_ptr;
    ptr_t            fill_ptr;
    ptr_t            rd_ptr;
    ptr_t            discard_cnt;
    logic [XLEN-1:0] ent_pc   [DEPTH];
    logic [31:0]     ent_data [DEPTH];
    logic [DEPTH-1:0] ent_filled;
    logic            fault_park;
    logic            fault_pending;

    logic [IW-1:0]   alloc_idx;
    logic [IW-1:0]   fill_idx;
    logic [IW-1:0]   rd_idx;
    ptr_t            occupancy;
    ptr_t            in_flight;
    logic [PW:0]     committed;
    logic            rsp_accept;
    logic            rsp_drop;
    logic            rsp_fill;
    logic            req_fire;
    logic            head_valid;
    logic            instr_fire;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target     = redirect_pc;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_target     = redirect_pc & ~XLEN'(3);
    assign redirect_misaligned = 1'b0;
`endif

    assign alloc_idx = alloc_ptr[IW-1:0];
    assign fill_idx  = fill_ptr[IW-1:0];
    assign rd_idx    = rd_ptr[IW-1:0];

    // Entries allocated but not yet consumed, plus requests whose data will be dropped.
    assign occupancy = alloc_ptr - rd_ptr;
    assign in_flight = alloc_ptr - fill_ptr;
    assign committed = {1'b0, occupancy} + {1'b0, discard_cnt};

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_accept = imem_rsp_valid && ((discard_cnt != '0) || (in_flight != '0));
    assign rsp_drop   = rsp_accept && (discard_cnt != '0);
    assign rsp_fill   = rsp_accept && (discard_cnt == '0) && !redirect_valid && !reset;

    assign imem_req_valid = !reset && !redirect_valid && !fault_park && (committed < DEPTH_CNT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign head_valid  = ent_filled[rd_idx] && (alloc_ptr != rd_ptr);
    assign instr_valid = !reset && !redirect_valid && (head_valid || fault_pending);
    assign instr       = fault_pending ? 32'h0 : ent_data[rd_idx];
    assign instr_pc    = fault_pending ? fetch_pc : ent_pc[rd_idx];
    assign instr_fault = instr_valid && fault_pending;
    assign instr_fire  = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc      <= RESET_VECTOR;
            alloc_ptr     <= '0;
            fill_ptr      <= '0;
            rd_ptr        <= '0;
            discard_cnt   <= '0;
            ent_filled    <= '0;
            fault_park    <= 1'b0;
            fault_pending <= 1'b0;
        end else if (redirect_valid) begin
            // Everything still owed by memory, minus the word arriving now, must be dropped.
            fetch_pc      <= redirect_target;
            alloc_ptr     <= '0;
            fill_ptr      <= '0;
            rd_ptr        <= '0;
            ent_filled    <= '0;
            discard_cnt   <= discard_cnt + in_flight - ptr_t'(rsp_accept);
            fault_park    <= redirect_misaligned;
            fault_pending <= redirect_misaligned;
        end else begin
            if (req_fire) begin
                ent_filled[alloc_idx] <= 1'b0;
                alloc_ptr             <= alloc_ptr + ptr_t'(1);
                fetch_pc              <= fetch_pc + XLEN'(4);
            end
            if (rsp_drop) begin
                discard_cnt <= discard_cnt - ptr_t'(1);
            end
            if (rsp_fill) begin
                ent_filled[fill_idx] <= 1'b1;
                fill_ptr             <= fill_ptr + ptr_t'(1);
            end
            if (instr_fire) begin
                if (fault_pending) begin
                    fault_pending <= 1'b0;
                end else begin
                    ent_filled[rd_idx] <= 1'b0;
                    rd_ptr             <= rd_ptr + ptr_t'(1);
                end
            end
        end
    end

    // NOTE: payload arrays carry no reset; the filled bits alone decide whether an entry is live.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            ent_pc[alloc_idx] <= fetch_pc;
        end
        if (rsp_fill) begin
            ent_data[fill_idx] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a fixed-latency instruction memory model.
// Build with FETCH_ALIGN_CHECK_EN defined to exercise the misaligned-redirect fault path.
module tb_fetch_unit;
    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_ready;

    fetch_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0100),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_fault(instr_fault),
        .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int cyc;
    int lat;

    // Memory delay line: slot k holds the response due k cycles from now.
    logic        mv [8];
    logic [31:0] ma [8];

    // Per-cycle snapshots of DUT outputs, indexed by cycle number since reset release.
    logic        s_rv  [64];
    logic [31:0] s_ra  [64];
    logic        s_iv  [64];
    logic [31:0] s_ipc [64];
    logic [31:0] s_ins [64];
    logic        s_flt [64];

    logic [31:0] req_log [$];
    logic [31:0] got_pc  [$];
    logic [31:0] got_ins [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic        fire;
        logic [31:0] fa;
        @(negedge clk);
        fire = imem_req_valid && imem_req_ready;
        fa   = imem_req_addr;
        if (cyc < 64) begin
            s_rv[cyc]  = imem_req_valid;
            s_ra[cyc]  = imem_req_addr;
            s_iv[cyc]  = instr_valid;
            s_ipc[cyc] = instr_pc;
            s_ins[cyc] = instr;
            s_flt[cyc] = instr_fault;
        end
        if (fire) req_log.push_back(fa);
        if (instr_valid && instr_ready) begin
            got_pc.push_back(instr_pc);
            got_ins.push_back(instr);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 7; k++) begin
            mv[k] = mv[k + 1];
            ma[k] = ma[k + 1];
        end
        mv[7] = 1'b0;
        if (reset) begin
            for (int k = 0; k < 8; k++) mv[k] = 1'b0;
        end else if (fire) begin
            mv[lat - 1] = 1'b1;
            ma[lat - 1] = fa;
        end
        imem_rsp_valid = mv[0];
        imem_rsp_data  = mv[0] ? mem_word(ma[0]) : 32'h0;
        cyc++;
    endtask

    // First reset cycle lands in slot 60, the last one in slot 0.
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        cyc = 60;
        tick();
        cyc = 0;
        tick();
        reset = 1'b0;
        cyc   = 1;
        req_log.delete();
        got_pc.delete();
        got_ins.delete();
    endtask

    task automatic redirect_tick(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lat   = 1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mv[k] = 1'b0;
            ma[k] = 32'h0;
        end

        // Streaming at L = 1: requests 0x100, 0x104, ...; first instruction in cycle 3.
        do_reset();
        repeat (8) tick();
        check("rst_req_valid", 64'(s_rv[0]), 64'(0));
        check("rst_req_addr", 64'(s_ra[0]), 64'h100);
        check("rst_instr_valid", 64'(s_iv[0]), 64'(0));
        check("rst_fault", 64'(s_flt[0]), 64'(0));
        check("c1_req_valid", 64'(s_rv[1]), 64'(1));
        check("c1_req_addr", 64'(s_ra[1]), 64'h100);
        check("c1_instr_valid", 64'(s_iv[1]), 64'(0));
        check("c1_fault", 64'(s_flt[1]), 64'(0));
        check("c2_req_addr", 64'(s_ra[2]), 64'h104);
        check("c2_instr_valid", 64'(s_iv[2]), 64'(0));
        for (int k = 3; k <= 8; k++) begin
            check($sformatf("stream_valid_c%0d", k), 64'(s_iv[k]), 64'(1));
            check($sformatf("stream_pc_c%0d", k), 64'(s_ipc[k]), 64'(32'h100 + 32'(4 * (k - 3))));
            check($sformatf("stream_instr_c%0d", k), 64'(s_ins[k]), 64'(mem_word(32'h100 + 32'(4 * (k - 3)))));
        end

        // Backpressure: mid-operation reset, then decode stalls for 10 cycles.
        instr_ready = 1'b0;
        do_reset();
        check("midrst_instr_valid", 64'(s_iv[60]), 64'(0));
        check("midrst_req_valid", 64'(s_rv[60]), 64'(0));
        repeat (10) tick();
        check("stall_req_count", 64'(req_log.size()), 64'(4));
        check("stall_req_valid", 64'(s_rv[10]), 64'(0));
        check("stall_instr_valid", 64'(s_iv[10]), 64'(1));
        check("stall_instr_pc", 64'(s_ipc[10]), 64'h100);
        instr_ready = 1'b1;
        repeat (8) tick();
        check("release_c11_req_valid", 64'(s_rv[11]), 64'(0));
        check("release_c12_req_valid", 64'(s_rv[12]), 64'(1));
        check("release_c12_req_addr", 64'(s_ra[12]), 64'h110);
        check("release_count", 64'(got_pc.size() >= 5), 64'(1));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("release_pc%0d", k), 64'(got_pc[k]), 64'(32'h100 + 32'(4 * k)));
        end

        // L = 3, three requests outstanding when redirecting to 0x200.
        lat = 3;
        do_reset();
        repeat (3) tick();
        redirect_tick(32'h200);
        repeat (8) tick();
        check("redir_c4_req_valid", 64'(s_rv[4]), 64'(0));
        check("redir_c5_req_valid", 64'(s_rv[5]), 64'(1));
        check("redir_c5_req_addr", 64'(s_ra[5]), 64'h200);
        for (int k = 4; k <= 8; k++) begin
            check($sformatf("redir_quiet_c%0d", k), 64'(s_iv[k]), 64'(0));
        end
        check("redir_c9_valid", 64'(s_iv[9]), 64'(1));
        check("redir_c9_pc", 64'(s_ipc[9]), 64'h200);
        check("redir_first_pc", 64'(got_pc[0]), 64'h200);
        check("redir_first_instr", 64'(got_ins[0]), 64'(mem_word(32'h200)));

        // Redirect coinciding with a response, then a second redirect one cycle later.
        do_reset();
        repeat (3) tick();
        redirect_tick(32'h300);
        tick();
        redirect_tick(32'h400);
        repeat (10) tick();
        check("dbl_c5_req_addr", 64'(s_ra[5]), 64'h300);
        check("dbl_c7_req_addr", 64'(s_ra[7]), 64'h400);
        check("dbl_c10_valid", 64'(s_iv[10]), 64'(0));
        check("dbl_c11_valid", 64'(s_iv[11]), 64'(1));
        check("dbl_first_pc", 64'(got_pc[0]), 64'h400);
        check("dbl_first_instr", 64'(got_ins[0]), 64'(mem_word(32'h400)));
        check("dbl_second_pc", 64'(got_pc[1]), 64'h404);

        // Fetch PC wrap at the top of the address space.
        lat = 1;
        do_reset();
        redirect_tick(32'hFFFF_FFFC);
        repeat (5) tick();
        check("wrap_c1_req_valid", 64'(s_rv[1]), 64'(0));
        check("wrap_c2_req_addr", 64'(s_ra[2]), 64'hFFFF_FFFC);
        check("wrap_c3_req_addr", 64'(s_ra[3]), 64'h0);
        check("wrap_pc0", 64'(got_pc[0]), 64'hFFFF_FFFC);
        check("wrap_pc1", 64'(got_pc[1]), 64'h0);

        // Misaligned redirect target 0x202.
        instr_ready = 1'b0;
        do_reset();
        redirect_tick(32'h202);
        repeat (3) tick();
        instr_ready = 1'b1;
        repeat (4) tick();
`ifdef FETCH_ALIGN_CHECK_EN
        check("align_c2_valid", 64'(s_iv[2]), 64'(1));
        check("align_c2_fault", 64'(s_flt[2]), 64'(1));
        check("align_c2_pc", 64'(s_ipc[2]), 64'h202);
        check("align_c2_instr", 64'(s_ins[2]), 64'h0);
        check("align_c4_held", 64'(s_flt[4]), 64'(1));
        check("align_c6_valid", 64'(s_iv[6]), 64'(0));
        check("align_c6_req_valid", 64'(s_rv[6]), 64'(0));
        check("align_req_count", 64'(req_log.size()), 64'(0));
        check("align_consumed", 64'(got_pc.size()), 64'(1));
`else
        check("align_c2_req_valid", 64'(s_rv[2]), 64'(1));
        check("align_c2_req_addr", 64'(s_ra[2]), 64'h200);
        check("align_c4_fault", 64'(s_flt[4]), 64'(0));
        check("align_c4_pc", 64'(s_ipc[4]), 64'h200);
        check("align_first_pc", 64'(got_pc[0]), 64'h200);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
